// File: rtl/button_sel_pkg.sv
// Shared width helpers and default parameter values for the button select controller.
package button_sel_pkg;

  localparam int DEF_NUM_CH          = 4;
  localparam int DEF_NUM_STATES      = 3;
  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 255;
  localparam int DEF_LONG_CYCLES     = 65535;

  function automatic int sel_width(input int n);
    int w;
    w = $clog2(n);
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n + 1);
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/button_debounce_ch.sv
// One channel: synchroniser, hold counter and modulo select register.
// Long-press-to-home is enabled by defining BUTTON_SEL_LONG_PRESS_EN.
module button_debounce_ch
  import button_sel_pkg::*;
#(
  parameter int NUM_STATES      = DEF_NUM_STATES,
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
  parameter int SEL_W           = sel_width(NUM_STATES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_btn,
  input  logic             i_lock,
  output logic [SEL_W-1:0] o_sel,
  output logic             o_changed
);

`ifdef BUTTON_SEL_LONG_PRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  localparam int CNT_MAX = LONG_EN ? LONG_CYCLES : DEBOUNCE_CYCLES;
  localparam int CNT_W   = cnt_width(CNT_MAX);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic [CNT_W-1:0]       r_cnt;
  logic [SEL_W-1:0]       r_sel;
  logic                   r_changed;

  logic                   w_s;
  logic                   w_release;
  logic                   w_qual;
  logic                   w_long;
  logic [CNT_W-1:0]       w_cnt_next;
  logic [SEL_W-1:0]       w_sel_adv;

  assign w_s = r_sync[SYNC_STAGES-1];

  // Next-state decode; release decisions use the count held before it clears.
  always_comb begin
    w_release  = r_prev & ~w_s;
    w_qual     = (32'(r_cnt) >= 32'(DEBOUNCE_CYCLES));
    w_long     = LONG_EN & (32'(r_cnt) >= 32'(LONG_CYCLES));
    w_cnt_next = '0;
    w_sel_adv  = '0;
    if (w_s) begin
      if (r_cnt == CNT_W'(CNT_MAX)) begin
        w_cnt_next = r_cnt;
      end else begin
        w_cnt_next = r_cnt + CNT_W'(1);
      end
    end else begin
      w_cnt_next = '0;
    end
    if (r_sel == SEL_W'(NUM_STATES - 1)) begin
      w_sel_adv = '0;
    end else begin
      w_sel_adv = r_sel + SEL_W'(1);
    end
  end

  // Channel state registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync    <= '0;
      r_prev    <= 1'b0;
      r_cnt     <= '0;
      r_sel     <= '0;
      r_changed <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_btn};
      r_prev <= w_s;
      r_cnt  <= w_cnt_next;
      // Locked releases are dropped outright rather than deferred.
      if (w_release && !i_lock && w_qual) begin
        r_sel     <= w_long ? '0 : w_sel_adv;
        r_changed <= 1'b1;
      end else begin
        r_sel     <= r_sel;
        r_changed <= 1'b0;
      end
    end
  end

  assign o_sel     = r_sel;
  assign o_changed = r_changed;

endmodule

// File: rtl/button_select_controller.sv
// Multi-channel push-button selector; lock fan-out and output packing only.
// Optional long-press-to-home: define BUTTON_SEL_LONG_PRESS_EN.
module button_select_controller
  import button_sel_pkg::*;
#(
  parameter int NUM_CH          = DEF_NUM_CH,
  parameter int NUM_STATES      = DEF_NUM_STATES,
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
  parameter int SEL_W           = sel_width(NUM_STATES)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       toggle,
  input  logic                    lock,
  output logic [NUM_CH*SEL_W-1:0] sel,
  output logic [NUM_CH-1:0]       changed
);

  logic [NUM_CH*SEL_W-1:0] w_sel;
  logic [NUM_CH-1:0]       w_changed;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    button_debounce_ch #(
      .NUM_STATES      (NUM_STATES),
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .LONG_CYCLES     (LONG_CYCLES),
      .SEL_W           (SEL_W)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .i_btn     (toggle[g]),
      .i_lock    (lock),
      .o_sel     (w_sel[g*SEL_W +: SEL_W]),
      .o_changed (w_changed[g])
    );
  end

  assign sel     = w_sel;
  assign changed = w_changed;

endmodule

// File: tb/tb_button_select_controller.sv
// Directed self-checking bench: NUM_CH=2, NUM_STATES=3, DEBOUNCE=4, LONG=16.
module tb_button_select_controller;

  localparam int NUM_CH = 2;
  localparam int SEL_W  = 2;

  logic                    clk;
  logic                    reset;
  logic [NUM_CH-1:0]       toggle;
  logic                    lock;
  logic [NUM_CH*SEL_W-1:0] sel;
  logic [NUM_CH-1:0]       changed;

  int         n_tests;
  int         n_fail;
  logic [3:0] cur_sel;

  button_select_controller #(
    .NUM_CH          (2),
    .NUM_STATES      (3),
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4),
    .LONG_CYCLES     (16)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .toggle  (toggle),
    .lock    (lock),
    .sel     (sel),
    .changed (changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Hold the masked buttons for 'hold' sampled cycles, release, and check the
  // update lands exactly on the third edge after release.
  task automatic do_press(input string tag, input logic [1:0] mask, input int hold,
                          input logic [3:0] exp_sel, input logic [1:0] exp_chg);
    toggle = toggle | mask;
    repeat (hold) tick();
    toggle = toggle & ~mask;
    tick();
    tick();
    check_eq({tag, "_pre_sel"}, 32'(sel), 32'(cur_sel));
    check_eq({tag, "_pre_chg"}, 32'(changed), 32'h0);
    tick();
    check_eq({tag, "_sel"}, 32'(sel), 32'(exp_sel));
    check_eq({tag, "_chg"}, 32'(changed), 32'(exp_chg));
    tick();
    check_eq({tag, "_chg_off"}, 32'(changed), 32'h0);
    cur_sel = exp_sel;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    cur_sel = 4'h0;
    reset   = 1'b1;
    toggle  = 2'b00;
    lock    = 1'b0;
    tick();
    check_eq("reset_sel", 32'(sel), 32'h0);
    check_eq("reset_chg", 32'(changed), 32'h0);
    tick();
    reset = 1'b0;
    tick();

    do_press("ch0_basic", 2'b01, 10, 4'b0001, 2'b01);
    do_press("ch0_glitch", 2'b01, 3, 4'b0001, 2'b00);

    toggle[0] = 1'b1;
    repeat (3) tick();
    toggle[0] = 1'b0;
    tick();
    do_press("ch0_split", 2'b01, 3, 4'b0001, 2'b00);

    do_press("ch1_p1", 2'b10, 5, 4'b0101, 2'b10);
    do_press("ch1_p2", 2'b10, 5, 4'b1001, 2'b10);
    do_press("ch1_wrap", 2'b10, 5, 4'b0001, 2'b10);
    do_press("both", 2'b11, 6, 4'b0110, 2'b11);

    lock = 1'b1;
    do_press("locked", 2'b01, 6, 4'b0110, 2'b00);
    lock = 1'b0;
    do_press("unlocked", 2'b01, 6, 4'b0100, 2'b01);
    do_press("to1", 2'b01, 4, 4'b0101, 2'b01);
    do_press("to2", 2'b01, 4, 4'b0110, 2'b01);

    do_press("long_from2", 2'b01, 20, 4'b0100, 2'b01);
`ifdef BUTTON_SEL_LONG_PRESS_EN
    do_press("long_from0", 2'b01, 20, 4'b0100, 2'b01);
    do_press("mid_hold", 2'b01, 10, 4'b0101, 2'b01);
`else
    do_press("long_from0", 2'b01, 20, 4'b0101, 2'b01);
    do_press("mid_hold", 2'b01, 10, 4'b0110, 2'b01);
`endif

    toggle[0] = 1'b1;
    repeat (10) tick();
    #2;
    reset = 1'b1;
    #1;
    check_eq("async_rst_sel", 32'(sel), 32'h0);
    check_eq("async_rst_chg", 32'(changed), 32'h0);
    tick();
    tick();
    reset   = 1'b0;
    cur_sel = 4'h0;
    do_press("post_rst_short", 2'b01, 2, 4'b0000, 2'b00);
    do_press("post_rst_exact", 2'b01, 4, 4'b0001, 2'b01);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
